// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
// Holds the FSM state encoding, control bundle and parameter defaults.
package fetch_ctrl_pkg;

  localparam int BOOT_CYCLES_DEF = 4;
  localparam int MAX_WAIT_DEF    = 15;
  localparam int STALL_W         = 16;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    WAIT  = 2'b10,
    HALT  = 2'b11
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic pc_sel;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic imem_req;
  } ctrl_t;

  function automatic ctrl_t mk_ctrl(
    input logic pw,
    input logic ps,
    input logic iw,
    input logic fi,
    input logic fe,
    input logic rq
  );
    ctrl_t c;
    c.pc_write    = pw;
    c.pc_sel      = ps;
    c.if_id_write = iw;
    c.if_id_flush = fi;
    c.id_ex_flush = fe;
    c.imem_req    = rq;
    return c;
  endfunction

  localparam ctrl_t CTRL_IDLE =
    mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  localparam ctrl_t CTRL_BRANCH =
    mk_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
  localparam ctrl_t CTRL_HAZARD =
    mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  localparam ctrl_t CTRL_NOTRDY =
    mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  localparam ctrl_t CTRL_NORMAL =
    mk_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

endpackage

// File: rtl/fetch_ctrl_if.sv
// Pipeline <-> fetch controller signal bundle.
// master: pipeline side (drives hazards/ready); slave: fetch_ctrl.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic               ImemReady;
  logic               LoadUseHazard;
  logic               BranchTaken;
  logic               PcWrite;
  logic               PcSel;
  logic               IfIdWrite;
  logic               IfIdFlush;
  logic               IdExFlush;
  logic               ImemReq;
  logic               Timeout;
  logic [STALL_W-1:0] StallCount;

  modport master (
    output ImemReady,
    output LoadUseHazard,
    output BranchTaken,
    input  PcWrite,
    input  PcSel,
    input  IfIdWrite,
    input  IfIdFlush,
    input  IdExFlush,
    input  ImemReq,
    input  Timeout,
    input  StallCount
  );

  modport slave (
    input  ImemReady,
    input  LoadUseHazard,
    input  BranchTaken,
    output PcWrite,
    output PcSel,
    output IfIdWrite,
    output IfIdFlush,
    output IdExFlush,
    output ImemReq,
    output Timeout,
    output StallCount
  );

endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority).
// Ports: clk, rstb, clr, inc -> count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: boot delay, stalls, flushes, fetch timeout.
// Ports: clk, rstb, bus (fetch_ctrl_if.slave: hazard/ready in, PC/IF-ID ctl out).
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = BOOT_CYCLES_DEF,
  parameter int MAX_WAIT    = MAX_WAIT_DEF
) (
  input  logic         clk,
  input  logic         rstb,
  fetch_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t             state;
  logic [2:0]         boot_cnt;
  logic               timeout;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [STALL_W-1:0] stall_cnt;
  ctrl_t              ctrl;

  logic active;
  logic boot_last;
  logic wait_last;
  logic wait_inc;
  logic wait_clr;
  logic stall_inc;

  assign active    = (state == FETCH) || (state == WAIT);
  assign boot_last = boot_cnt == 3'(BOOT_CYCLES - 1);
  // Next low cycle would make MAX_WAIT consecutive misses.
  assign wait_last = wait_cnt >= WAIT_W'(MAX_WAIT - 1);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= BOOT;
      boot_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          if (boot_last) state <= FETCH;
          else boot_cnt <= boot_cnt + 3'd1;
        end
        FETCH: begin
          if (!bus.BranchTaken && !bus.ImemReady)
            state <= WAIT;
        end
        WAIT: begin
          if (bus.BranchTaken || bus.ImemReady) begin
            state <= FETCH;
          end else if (wait_last) begin
            state   <= HALT;
            timeout <= 1'b1;
          end
        end
        HALT: state <= HALT;
      endcase
    end
  end

  // Branch/hazard/ready can coincide, so first match wins.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (active) begin
      priority case (1'b1)
        bus.BranchTaken:   ctrl = CTRL_BRANCH;
        bus.LoadUseHazard: ctrl = CTRL_HAZARD;
        !bus.ImemReady:    ctrl = CTRL_NOTRDY;
        default:           ctrl = CTRL_NORMAL;
      endcase
    end
  end

  // Wait counter is always zero in FETCH, so a miss there yields 1.
  assign wait_inc  = active && !bus.ImemReady && !bus.BranchTaken;
  assign wait_clr  = active && (bus.BranchTaken ||
                     ((state == WAIT) && bus.ImemReady));
  assign stall_inc = active && !ctrl.pc_write;

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rstb  (rstb),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .count (wait_cnt)
  );

  sat_counter #(.W(STALL_W)) u_stall_cnt (
    .clk   (clk),
    .rstb  (rstb),
    .clr   (1'b0),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  assign bus.PcWrite    = ctrl.pc_write;
  assign bus.PcSel      = ctrl.pc_sel;
  assign bus.IfIdWrite  = ctrl.if_id_write;
  assign bus.IfIdFlush  = ctrl.if_id_flush;
  assign bus.IdExFlush  = ctrl.id_ex_flush;
  assign bus.ImemReq    = ctrl.imem_req;
  assign bus.Timeout    = timeout;
  assign bus.StallCount = stall_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed + random bench for fetch_ctrl against a cycle-level reference model.
// Model tracks boot cycles left, consecutive miss run, halt and stall totals.
module tb_fetch_ctrl;

  localparam int BC = 4;
  localparam int MW = 15;

  logic clk  = 1'b0;
  logic rstb = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .BOOT_CYCLES (BC),
    .MAX_WAIT    (MW)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  int boot_left;
  bit halted;
  int low_run;
  bit m_timeout;
  int m_stalls;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    boot_left = BC;
    halted    = 1'b0;
    low_run   = 0;
    m_timeout = 1'b0;
    m_stalls  = 0;
  endtask

  // {PcWrite, PcSel, IfIdWrite, IfIdFlush, IdExFlush, ImemReq}
  function automatic logic [5:0] expect_out(input logic r, input logic h,
                                            input logic b);
    if (boot_left > 0 || halted) return 6'b000110;
    if (b)                       return 6'b110111;
    if (h)                       return 6'b000011;
    if (!r)                      return 6'b000101;
    return 6'b101001;
  endfunction

  function automatic logic [5:0] dut_out();
    return {bus.PcWrite, bus.PcSel, bus.IfIdWrite,
            bus.IfIdFlush, bus.IdExFlush, bus.ImemReq};
  endfunction

  task automatic model_update(input logic r, input logic b,
                              input logic pw);
    if (boot_left > 0) begin
      boot_left--;
    end else if (!halted) begin
      if (!pw && m_stalls < 65535) m_stalls++;
      if (b) begin
        low_run = 0;
      end else if (!r) begin
        low_run++;
        if (low_run >= MW) begin
          halted    = 1'b1;
          m_timeout = 1'b1;
        end
      end else begin
        low_run = 0;
      end
    end
  endtask

  // Called at posedge+1; checks mid-cycle, returns at next posedge+1.
  task automatic step(input logic r, input logic h, input logic b,
                      input string tag);
    logic [5:0] e;
    bus.ImemReady     = r;
    bus.LoadUseHazard = h;
    bus.BranchTaken   = b;
    @(negedge clk);
    e = expect_out(r, h, b);
    chk({tag, "/ctl"}, 32'(dut_out()), 32'(e));
    chk({tag, "/tmo"}, 32'(bus.Timeout), 32'(m_timeout));
    chk({tag, "/stl"}, 32'(bus.StallCount), 32'(m_stalls));
    model_update(r, b, e[5]);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous assert mid-cycle, release just after an edge.
  task automatic do_reset(input string tag);
    bus.ImemReady     = 1'b1;
    bus.LoadUseHazard = 1'b0;
    bus.BranchTaken   = 1'b0;
    rstb = 1'b0;
    #2;
    chk({tag, "/rctl"}, 32'(dut_out()), 32'h06);
    chk({tag, "/rtmo"}, 32'(bus.Timeout), 32'h0);
    chk({tag, "/rstl"}, 32'(bus.StallCount), 32'h0);
    @(posedge clk);
    #1;
    rstb = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.ImemReady     = 1'b1;
    bus.LoadUseHazard = 1'b0;
    bus.BranchTaken   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por/ctl", 32'(dut_out()), 32'h06);
    chk("por/tmo", 32'(bus.Timeout), 32'h0);
    chk("por/stl", 32'(bus.StallCount), 32'h0);
    rstb = 1'b1;

    repeat (10) step(1'b1, 1'b0, 1'b0, "boot");
    chk("boot/stl0", 32'(bus.StallCount), 32'h0);

    repeat (3) step(1'b0, 1'b0, 1'b0, "nr3");
    step(1'b1, 1'b0, 1'b0, "nr3_end");
    chk("nr3/stl3", 32'(bus.StallCount), 32'h3);

    step(1'b0, 1'b0, 1'b0, "br_w0");
    step(1'b0, 1'b0, 1'b0, "br_w1");
    step(1'b0, 1'b0, 1'b1, "br_w2");
    step(1'b1, 1'b0, 1'b0, "br_post");

    step(1'b1, 1'b1, 1'b1, "brhz_f");
    step(1'b0, 1'b0, 1'b0, "brhz_w0");
    step(1'b0, 1'b1, 1'b1, "brhz_w1");

    step(1'b0, 1'b0, 1'b0, "hz_w0");
    step(1'b0, 1'b1, 1'b0, "hz_w1");
    step(1'b0, 1'b0, 1'b0, "hz_w2");
    step(1'b1, 1'b0, 1'b0, "hz_end");

    repeat (15) step(1'b0, 1'b0, 1'b0, "tmo_run");
    repeat (3) step(1'b1, 1'b0, 1'b1, "halt");
    chk("halt/tmo", 32'(bus.Timeout), 32'h1);
    chk("halt/req", 32'(bus.ImemReq), 32'h0);
    do_reset("halt_rst");
    repeat (6) step(1'b1, 1'b0, 1'b0, "reboot");

    repeat (6) step(1'b0, 1'b0, 1'b0, "midwait");
    do_reset("wait_rst");
    repeat (6) step(1'b1, 1'b0, 1'b0, "reboot2");

    for (int s = 0; s < 40; s++) begin
      int thr;
      thr = $urandom_range(0, 10);
      for (int c = 0; c < 30; c++) begin
        logic r, h, b;
        r = $urandom_range(0, 9) < thr;
        h = $urandom_range(0, 4) == 0;
        b = $urandom_range(0, 7) == 0;
        step(r, h, b, "rnd");
      end
      if (halted || $urandom_range(0, 3) == 0) do_reset("rnd_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
